// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared CNN pipeline types and helpers
package conv_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int MAX_DW         = 64;

  function automatic int out_dim(input int in_dim);
    return in_dim / 2;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Callers sign-extend narrower elements to MAX_DW before comparing.
  function automatic logic signed [MAX_DW-1:0] max2(
    input logic signed [MAX_DW-1:0] a,
    input logic signed [MAX_DW-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// rtl/pool_line_buf.sv - flop-based line buffer holding even-row pair maxima
module pool_line_buf
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 3,
  parameter int AW         = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  // Every entry is written on an even row before the odd row reads it, so no reset.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/maxpool2d_stream.sv
// rtl/maxpool2d_stream.sv - streaming 2x2/stride-2 signed max pool; MAXPOOL_RELU_EN adds input ReLU
module maxpool2d_stream
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CHANNELS   = 32,
  parameter int IN_HEIGHT  = 7,
  parameter int IN_WIDTH   = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int OUT_HEIGHT = out_dim(IN_HEIGHT);
  localparam int OUT_WIDTH  = out_dim(IN_WIDTH);
  localparam int CW         = cnt_width(IN_WIDTH);
  localparam int RW         = cnt_width(IN_HEIGHT);
  localparam int HW         = cnt_width(CHANNELS);
  localparam int LAW        = cnt_width(OUT_WIDTH);

  function automatic logic [DATA_WIDTH-1:0] smax(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic signed [MAX_DW-1:0] r;
    r = max2(MAX_DW'($signed(a)), MAX_DW'($signed(b)));
    return r[DATA_WIDTH-1:0];
  endfunction

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [HW-1:0]         chan;
  logic [DATA_WIDTH-1:0] px;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] lb_rd_data;
  logic [LAW-1:0]        lb_addr;
  logic                  in_fire;
  logic                  out_fire;
  logic                  col_last;
  logic                  row_last;
  logic                  chan_last;
  logic                  in_win;
  logic                  pair_end;
  logic                  lb_wr;
  logic                  win_done;
  logic                  win_last;

  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

`ifdef MAXPOOL_RELU_EN
  assign px = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
  assign px = in_data;
`endif

  assign col_last  = (int'(col) == IN_WIDTH - 1);
  assign row_last  = (int'(row) == IN_HEIGHT - 1);
  assign chan_last = (int'(chan) == CHANNELS - 1);

  // A trailing odd row or column falls outside every window and is dropped here.
  assign in_win   = (int'(row) < 2 * OUT_HEIGHT) && (int'(col) < 2 * OUT_WIDTH);
  assign pair_end = in_fire && in_win && col[0];
  assign lb_wr    = pair_end && !row[0];
  assign win_done = pair_end && row[0];
  assign win_last = chan_last && (int'(row) == 2 * OUT_HEIGHT - 1)
                    && (int'(col) == 2 * OUT_WIDTH - 1);
  assign lb_addr  = LAW'(col >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      col  <= '0;
      row  <= '0;
      chan <= '0;
    end else if (in_fire) begin
      if (col_last) begin
        col <= '0;
        if (row_last) begin
          row  <= '0;
          chan <= chan_last ? '0 : chan + 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire && in_win && !col[0]) begin
      hold <= px;
    end
  end

  pool_line_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (OUT_WIDTH),
    .AW        (LAW)
  ) u_line_buf (
    .clk    (clk),
    .wr_en  (lb_wr),
    .wr_addr(lb_addr),
    .wr_data(smax(hold, px)),
    .rd_addr(lb_addr),
    .rd_data(lb_rd_data)
  );

  // A completing window reloads the register even while the old value drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (win_done) begin
      out_valid <= 1'b1;
      out_data  <= smax(smax(lb_rd_data, px), hold);
      out_last  <= win_last;
    end else if (out_fire) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_maxpool2d_stream.sv
// tb/tb_maxpool2d_stream.sv - directed and scoreboard bench for maxpool2d_stream
module tb_maxpool2d_stream;

  localparam int DW = 32;
  localparam int C  = 32;
  localparam int H  = 7;
  localparam int W  = 7;
  localparam int OH = 3;
  localparam int OW = 3;
  localparam int TSZ = C * H * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [DW-1:0] a_in_data, a_out_data;
  logic          b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [DW-1:0] b_in_data, b_out_data;

  maxpool2d_stream dut_a (
    .clk(clk), .rst(a_rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last)
  );

  maxpool2d_stream #(.DATA_WIDTH(DW), .CHANNELS(1), .IN_HEIGHT(4), .IN_WIDTH(4)) dut_b (
    .clk(clk), .rst(b_rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef MAXPOOL_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [DW-1:0] gmax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  function automatic logic [DW-1:0] gen(input int mode, input int t, input int flat);
    if (mode == 0) return DW'(flat);
    return DW'(((flat * 37 + t * 11) % 401) - 200);
  endfunction

  logic [DW:0]   exp_q[$];
  logic [DW-1:0] first_out, last_out;

  task automatic build_exp(input int mode, input int t);
    logic [DW-1:0] m;
    for (int c = 0; c < C; c++)
      for (int i = 0; i < OH; i++)
        for (int j = 0; j < OW; j++) begin
          m = relu(gen(mode, t, (c * H + 2 * i) * W + 2 * j));
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++)
              m = gmax(m, relu(gen(mode, t, (c * H + 2 * i + dy) * W + 2 * j + dx)));
          exp_q.push_back({(c == C - 1 && i == OH - 1 && j == OW - 1), m});
        end
  endtask

  task automatic run_stream(input int mode, input int n_t, input int rand_en, input int stall_idx);
    int in_idx = 0;
    int got = 0;
    int cyc = 0;
    int exp_n;
    int stall_cnt = 0;
    int total_in = n_t * TSZ;
    logic fi, fo, ol;
    logic [DW-1:0] od, stall_data, e_data;
    logic [DW:0] e;
    exp_q.delete();
    for (int t = 0; t < n_t; t++) build_exp(mode, t);
    exp_n = exp_q.size();
    stall_data = '0;
    while ((in_idx < total_in || got < exp_n) && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      a_in_valid  = (in_idx < total_in) && (rand_en == 0 || $urandom_range(0, 3) != 0);
      a_in_data   = (in_idx < total_in) ? gen(mode, in_idx / TSZ, in_idx % TSZ) : '0;
      a_out_ready = (rand_en == 0) || ($urandom_range(0, 2) != 0);
      if (stall_idx >= 0 && got == stall_idx && a_out_valid && stall_cnt < 10) begin
        a_out_ready = 1'b0;
        a_in_valid  = (in_idx < total_in);
        if (stall_cnt == 0) stall_data = a_out_data;
        #1;
        chk("stall_in_ready", a_in_ready, 0);
        chk("stall_out_data", a_out_data, stall_data);
        stall_cnt++;
      end else begin
        #1;
      end
      fi = a_in_valid && a_in_ready;
      fo = a_out_valid && a_out_ready;
      od = a_out_data;
      ol = a_out_last;
      @(posedge clk);
      if (fi) in_idx++;
      if (fo) begin
        if (exp_q.size() == 0) begin
          chk("extra_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          e_data = e[DW-1:0];
          chk($sformatf("out_data[%0d]", got), od, e_data);
          chk($sformatf("out_last[%0d]", got), ol, e[DW]);
          if (got == 0) first_out = od;
          last_out = od;
        end
        got++;
      end
    end
    chk("stream_timeout", (cyc >= 30000), 0);
    chk("out_count", got, exp_n);
    if (stall_idx >= 0) chk("stall_len", stall_cnt, 10);
    @(negedge clk);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
  endtask

  typedef struct {
    logic [DW-1:0] din;
    logic          ev;
    logic [DW-1:0] ed;
    logic          el;
  } vec_t;

  vec_t          tv[16];
  logic [DW-1:0] nv[16];
  logic [DW-1:0] nres[$];
  logic [DW-1:0] exp_neg;
  int            n_fired;
  int            cyc;

  initial begin
    for (int i = 0; i < 16; i++) tv[i] = '{din: DW'(i), ev: 1'b0, ed: '0, el: 1'b0};
    tv[5]  = '{din: DW'(5),  ev: 1'b1, ed: DW'(5),  el: 1'b0};
    tv[7]  = '{din: DW'(7),  ev: 1'b1, ed: DW'(7),  el: 1'b0};
    tv[13] = '{din: DW'(13), ev: 1'b1, ed: DW'(13), el: 1'b0};
    tv[15] = '{din: DW'(15), ev: 1'b1, ed: DW'(15), el: 1'b1};
    nv = '{-5, -3, 2, 2, -9, -1, 3, 3, 1, 1, 1, 1, 1, 1, 1, 1};

    a_rst = 1'b1; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_rst = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_out_last", a_out_last, 0);
    chk("rst_a_out_data", a_out_data, 0);
    chk("rst_b_out_valid", b_out_valid, 0);
    chk("rst_b_out_data", b_out_data, 0);
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;
    #1;
    chk("rst_a_in_ready", a_in_ready, 1);
    chk("rst_b_in_ready", b_in_ready, 1);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      b_in_valid = 1'b1; b_in_data = tv[i].din; b_out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("v4_valid[%0d]", i), b_out_valid, tv[i].ev);
      if (tv[i].ev) chk($sformatf("v4_data[%0d]", i), b_out_data, tv[i].ed);
      chk($sformatf("v4_last[%0d]", i), b_out_last, tv[i].el);
    end
    @(negedge clk);
    b_in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("v4_drained", b_out_valid, 0);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      b_in_valid = (i < 16); b_in_data = (i < 16) ? nv[i] : '0;
      @(posedge clk);
      #1;
      if (b_out_valid) nres.push_back(b_out_data);
    end
    @(negedge clk);
    b_in_valid = 1'b0;
`ifdef MAXPOOL_RELU_EN
    exp_neg = '0;
`else
    exp_neg = 32'hFFFF_FFFF;
`endif
    chk("neg_count", nres.size(), 4);
    if (nres.size() == 4) begin
      chk("neg_window", nres[0], exp_neg);
      chk("neg_w1", nres[1], 3);
      chk("neg_w2", nres[2], 1);
      chk("neg_w3", nres[3], 1);
    end

    run_stream(0, 1, 0, -1);
    chk("first_out", first_out, 8);
    chk("last_out", last_out, 1559);

    run_stream(1, 1, 0, 5);
    run_stream(1, 3, 1, -1);

    n_fired = 0;
    cyc = 0;
    while (n_fired < 20 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      a_in_valid = 1'b1; a_in_data = gen(1, 7, n_fired); a_out_ready = 1'b1;
      #1;
      if (a_in_ready) n_fired++;
      @(posedge clk);
    end
    chk("pre_reset_inputs", n_fired, 20);
    @(negedge clk);
    a_in_valid = 1'b0; a_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", a_out_valid, 0);
    chk("midrst_out_last", a_out_last, 0);
    @(negedge clk);
    a_rst = 1'b0;
    #1;
    chk("midrst_in_ready", a_in_ready, 1);
    chk("midrst_valid_after", a_out_valid, 0);
    run_stream(1, 1, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
